// File: rtl/ahb_master.sv
// AHB-Lite single-word master with a two-slot (address/data phase) pipeline.
// A two-cycle ERROR response cancels the queued address phase, which is then re-issued.
module ahb_master (
    input  logic        EXTM_HCLK,
    input  logic        EXTM_HRST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic [31:0] EXTM_HADDR,
    output logic [1:0]  EXTM_HTRANS,
    output logic        EXTM_HWRITE,
    output logic [2:0]  EXTM_HSIZE,
    output logic [2:0]  EXTM_HBURST,
    output logic [31:0] EXTM_HWDATA,
    input  logic        EXTM_HREADY,
    input  logic        EXTM_HRESP,
    input  logic [31:0] EXTM_HRDATA
);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic        a_valid;
    logic        a_write;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        cancel;

    logic accept;
    logic advance;
    logic complete;
    logic err_first;

    assign req_ready = !EXTM_HRST &&
                       (!a_valid || (EXTM_HREADY && !cancel && !(EXTM_HRESP && !EXTM_HREADY)));
    assign accept    = req_valid && req_ready;
    assign advance   = EXTM_HREADY && !cancel;
    assign complete  = EXTM_HREADY && d_valid;
    assign err_first = EXTM_HRESP && !EXTM_HREADY && d_valid;

    assign EXTM_HADDR  = a_addr;
    assign EXTM_HWRITE = a_write;
    assign EXTM_HTRANS = (a_valid && !cancel) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign EXTM_HWDATA = d_wdata;
    assign EXTM_HSIZE  = 3'b010;
    assign EXTM_HBURST = 3'b000;

    always_ff @(posedge EXTM_HCLK or posedge EXTM_HRST) begin
        if (EXTM_HRST) begin
            a_valid   <= 1'b0;
            a_write   <= 1'b0;
            a_addr    <= '0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            d_wdata   <= '0;
            cancel    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= complete;
            rsp_error <= complete && EXTM_HRESP;
            rsp_rdata <= (complete && !d_write && !EXTM_HRESP) ? EXTM_HRDATA : '0;

            if (advance) begin
                d_valid <= a_valid;
                d_write <= a_write;
                d_wdata <= a_wdata;
                a_valid <= accept;
                if (accept) begin
                    a_addr  <= req_addr;
                    a_write <= req_write;
                    a_wdata <= req_wdata;
                end
            end else begin
                // Second ERROR cycle retires D without promoting the cancelled A slot.
                if (cancel && EXTM_HREADY) begin
                    d_valid <= 1'b0;
                    cancel  <= 1'b0;
                end else if (err_first) begin
                    cancel <= 1'b1;
                end
                if (accept) begin
                    a_valid <= 1'b1;
                    a_addr  <= req_addr;
                    a_write <= req_write;
                    a_wdata <= req_wdata;
                end
            end
        end
    end
endmodule

// File: tb/tb_ahb_master.sv
// Self-checking bench for ahb_master: directed scenarios plus randomized traffic
// against an in-order transaction model and a behavioural AHB slave.
module tb_ahb_master;
    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = '0;

    int errors = 0;
    int checks = 0;

    xfer_t issue_q[$];
    xfer_t rsp_q[$];

    // Slave data-phase state and knobs
    bit          dp_valid = 1'b0;
    xfer_t       dp;
    int          dp_wait = 0;
    bit          dp_err_stage = 1'b0;
    int          fixed_wait = 0;
    bit          rand_wait = 1'b0;
    bit          spurious_en = 1'b0;
    logic [1:0]  bus_htrans = 2'b00;
    logic [31:0] bus_haddr = '0;
    logic        bus_hwrite = 1'b0;
    xfer_t       sb_x;
    logic        sb_err;
    logic [31:0] sb_data;

    ahb_master dut (
        .EXTM_HCLK  (clk),
        .EXTM_HRST  (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .EXTM_HADDR (haddr),
        .EXTM_HTRANS(htrans),
        .EXTM_HWRITE(hwrite),
        .EXTM_HSIZE (hsize),
        .EXTM_HBURST(hburst),
        .EXTM_HWDATA(hwdata),
        .EXTM_HREADY(hready),
        .EXTM_HRESP (hresp),
        .EXTM_HRDATA(hrdata)
    );

    always #5 clk = ~clk;

    function automatic logic err_fn(input logic [31:0] a);
        return a[31:28] == 4'hB;
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ~(a - 32'hE800_0000);
    endfunction

    // Slave drives its response mid-cycle and checks write data in the data phase
    always @(negedge clk) begin
        bus_htrans = htrans;
        bus_haddr  = haddr;
        bus_hwrite = hwrite;
        hrdata     = $urandom;
        if (rst || !dp_valid) begin
            hready = 1'b1;
            hresp  = spurious_en && ($urandom_range(0, 3) == 0);
        end else if (dp_wait > 0) begin
            hready = 1'b0;
            hresp  = 1'b0;
        end else if (err_fn(dp.addr)) begin
            hready = dp_err_stage;
            hresp  = 1'b1;
        end else begin
            hready = 1'b1;
            hresp  = 1'b0;
            if (!dp.write) hrdata = mem_fn(dp.addr);
        end
        if (!rst && dp_valid && dp.write) begin
            checks++;
            if (hwdata !== dp.wdata) begin
                errors++;
                $display("[TB] FAIL hwdata: got %h expected %h", hwdata, dp.wdata);
            end
        end
    end

    // Slave retires data phases and captures address phases on the clock edge
    always @(posedge clk) begin
        if (rst) begin
            dp_valid = 1'b0;
        end else begin
            if (dp_valid) begin
                if (hready) dp_valid = 1'b0;
                else if (dp_wait > 0) dp_wait--;
                else dp_err_stage = 1'b1;
            end
            if (hready && bus_htrans == 2'b10) begin
                checks++;
                if (issue_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL issue: unexpected NONSEQ at %h", bus_haddr);
                end else begin
                    dp = issue_q.pop_front();
                    if (bus_haddr !== dp.addr || bus_hwrite !== dp.write) begin
                        errors++;
                        $display("[TB] FAIL issue: got addr %h write %b expected addr %h write %b",
                                 bus_haddr, bus_hwrite, dp.addr, dp.write);
                    end
                    dp_valid     = 1'b1;
                    dp_wait      = rand_wait ? int'($urandom_range(0, 2)) : fixed_wait;
                    dp_err_stage = 1'b0;
                end
            end
        end
    end

    // In-order response scoreboard
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            checks++;
            if (rsp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL response: got unexpected rsp_valid, expected none");
            end else begin
                sb_x    = rsp_q.pop_front();
                sb_err  = err_fn(sb_x.addr);
                sb_data = (sb_x.write || sb_err) ? 32'h0 : mem_fn(sb_x.addr);
                if (rsp_error !== sb_err || rsp_rdata !== sb_data) begin
                    errors++;
                    $display("[TB] FAIL response %h: got err %b data %h expected err %b data %h",
                             sb_x.addr, rsp_error, rsp_rdata, sb_err, sb_data);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end

    // Called at negedge+1; returns at negedge+1 of the cycle after acceptance, req_valid left high
    task automatic issue(input logic [31:0] addr, input logic write, input logic [31:0] wdata);
        xfer_t x;
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = addr;
        req_write = write;
        req_wdata = wdata;
        #1;
        while (req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            #2;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL accept %h: got req_ready %b expected 1", addr, req_ready);
            req_valid = 1'b0;
        end else begin
            x.addr  = addr;
            x.write = write;
            x.wdata = wdata;
            issue_q.push_back(x);
            rsp_q.push_back(x);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        req_valid = 1'b0;
        while (rsp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL %s drain: got %0d outstanding expected 0", name, rsp_q.size());
        end
        rsp_q.delete();
        issue_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset: got trans %b addr %h wr %b wdata %h rv %b rd %h re %b rdy %b expected all 0",
                     htrans, haddr, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_error, req_ready);
        end
        checks++;
        if (hsize !== 3'b010 || hburst !== 3'b000) begin
            errors++;
            $display("[TB] FAIL constants: got hsize %b hburst %b expected 010 000", hsize, hburst);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || htrans !== 2'b00) begin
            errors++;
            $display("[TB] FAIL release: got rdy %b trans %b expected 1 00", req_ready, htrans);
        end
        @(negedge clk);
        #1;
    endtask

    task automatic test_single_read();
        issue(32'hE800_0000, 1'b0, 32'h0);
        req_valid = 1'b0;
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'hE800_0000 || hwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single addr: got trans %b addr %h expected 10 e8000000", htrans, haddr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (htrans !== 2'b00 || rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single data: got trans %b rv %b expected 00 0", htrans, rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_FFFF || rsp_error !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single rsp: got rv %b rd %h re %b expected 1 ffffffff 0",
                     rsp_valid, rsp_rdata, rsp_error);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single pulse: got rv %b expected 0", rsp_valid);
        end
        drain("single");
    endtask

    task automatic test_back_to_back();
        issue(32'hE800_0004, 1'b1, 32'h1234_5678);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'hE800_0004 || hwrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b write addr: got trans %b addr %h wr %b expected 10 e8000004 1",
                     htrans, haddr, hwrite);
        end
        issue(32'hE800_0004, 1'b0, 32'h0);
        req_valid = 1'b0;
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'hE800_0004 || hwrite !== 1'b0 || hwdata !== 32'h1234_5678) begin
            errors++;
            $display("[TB] FAIL b2b read addr: got trans %b addr %h wr %b wdata %h expected 10 e8000004 0 12345678",
                     htrans, haddr, hwrite, hwdata);
        end
        drain("back_to_back");
    endtask

    task automatic test_wait_states();
        xfer_t x;
        fixed_wait = 3;
        issue(32'hE800_0010, 1'b0, 32'hCAFE_0001);
        issue(32'hE800_0014, 1'b0, 32'hCAFE_0002);
        req_addr  = 32'hE800_0018;
        req_write = 1'b0;
        req_wdata = 32'hCAFE_0003;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (htrans !== 2'b10 || haddr !== 32'hE800_0014 || hwdata !== 32'hCAFE_0001 ||
                req_ready !== 1'b0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL wait %0d: got trans %b addr %h wdata %h rdy %b rv %b expected 10 e8000014 cafe0001 0 0",
                         k, htrans, haddr, hwdata, req_ready, rsp_valid);
            end
            @(negedge clk);
            #1;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait release: got rdy %b expected 1", req_ready);
            req_valid = 1'b0;
        end else begin
            x.addr  = 32'hE800_0018;
            x.write = 1'b0;
            x.wdata = 32'hCAFE_0003;
            issue_q.push_back(x);
            rsp_q.push_back(x);
        end
        @(negedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL wait rsp: got rv %b expected 1", rsp_valid);
        end
        drain("wait_states");
        fixed_wait = 0;
    endtask

    task automatic test_error();
        issue(32'hB000_0020, 1'b0, 32'h0);
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'hB000_0020) begin
            errors++;
            $display("[TB] FAIL err A addr: got trans %b addr %h expected 10 b0000020", htrans, haddr);
        end
        issue(32'hE800_0024, 1'b0, 32'h0);
        req_valid = 1'b0;
        checks++;
        if (htrans !== 2'b10 || haddr !== 32'hE800_0024) begin
            errors++;
            $display("[TB] FAIL err first: got trans %b addr %h expected 10 e8000024", htrans, haddr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (htrans !== 2'b00 || haddr !== 32'hE800_0024) begin
            errors++;
            $display("[TB] FAIL err second: got trans %b addr %h expected 00 e8000024", htrans, haddr);
        end
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_error !== 1'b1 || rsp_rdata !== 32'h0 ||
            htrans !== 2'b10 || haddr !== 32'hE800_0024) begin
            errors++;
            $display("[TB] FAIL err rsp: got rv %b re %b rd %h trans %b addr %h expected 1 1 0 10 e8000024",
                     rsp_valid, rsp_error, rsp_rdata, htrans, haddr);
        end
        drain("error");
    endtask

    task automatic test_reset_midflight();
        fixed_wait = 2;
        issue(32'hE800_0030, 1'b1, 32'h5555_AAAA);
        issue(32'hE800_0034, 1'b0, 32'h0);
        req_valid = 1'b0;
        rst = 1'b1;
        issue_q.delete();
        rsp_q.delete();
        #1;
        checks++;
        if (htrans !== 2'b00 || haddr !== 32'h0 || hwrite !== 1'b0 || hwdata !== 32'h0 ||
            rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || rsp_error !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset: got trans %b addr %h wr %b wdata %h rv %b rd %h re %b rdy %b expected all 0",
                     htrans, haddr, hwrite, hwdata, rsp_valid, rsp_rdata, rsp_error, req_ready);
        end
        repeat (2) begin
            @(negedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset pulse: got rv %b expected 0", rsp_valid);
            end
        end
        fixed_wait = 0;
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || htrans !== 2'b00) begin
            errors++;
            $display("[TB] FAIL midreset release: got rdy %b trans %b expected 1 00", req_ready, htrans);
        end
        @(negedge clk);
        #1;
        issue(32'hE800_0038, 1'b0, 32'h0);
        drain("reset_midflight");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int gap;
        rand_wait   = 1'b1;
        spurious_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            a = {($urandom_range(0, 5) == 0) ? 4'hB : 4'hE, 26'($urandom), 2'b00};
            issue(a, 1'($urandom), $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                req_valid = 1'b0;
                repeat (gap) begin
                    @(negedge clk);
                    #1;
                end
            end
        end
        drain("random");
        rand_wait   = 1'b0;
        spurious_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_wait_states();
        test_error();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameters: none; transfers fixed to 32-bit word, SINGLE burst, NONSEQ only.
REQ-002 EXTM_HCLK  in  1  sole clock; all state updates on rising edge.
REQ-003 EXTM_HRST  in  1  reset, asynchronous, active-high.
REQ-004 req_valid  in  1  client transfer request.
REQ-005 req_ready  out  1  request accepted on edge where req_valid && req_ready.
REQ-006 req_write  in  1  1 = write, 0 = read.
REQ-007 req_addr  in  32  byte address, word-aligned by client.
REQ-008 req_wdata  in  32  write data.
REQ-009 rsp_valid  out  1  one-cycle pulse: one transfer completed; no backpressure.
REQ-010 rsp_rdata  out  32  read data; 0 for writes.
REQ-011 rsp_error  out  1  transfer ended with ERROR response.
REQ-012 EXTM_HADDR  out  32  AHB address.
REQ-013 EXTM_HTRANS  out  2  AHB transfer type (IDLE=00, NONSEQ=10).
REQ-014 EXTM_HWRITE  out  1  AHB direction.
REQ-015 EXTM_HSIZE  out  3  constant 3'b010.
REQ-016 EXTM_HBURST  out  3  constant 3'b000.
REQ-017 EXTM_HWDATA  out  32  AHB write data, data phase.
REQ-018 EXTM_HREADY  in  1  slave ready / phase advance.
REQ-019 EXTM_HRESP  in  1  slave response, 0 OKAY, 1 ERROR.
REQ-020 EXTM_HRDATA  in  32  slave read data.

Function
REQ-021 Two registered slots: A (address phase: valid, addr, write, wdata) and D (data phase: valid, write, wdata); max 2 transfers outstanding.
REQ-022 EXTM_HADDR/EXTM_HWRITE driven from A; EXTM_HTRANS = NONSEQ when A.valid and not cancel, else IDLE; EXTM_HWDATA driven from D.wdata.
REQ-023 req_ready = !EXTM_HRST && (!A.valid || (EXTM_HREADY && !cancel && !(EXTM_HRESP && !EXTM_HREADY))).
REQ-024 Edge with EXTM_HREADY=1 and not cancel: D <= A; A <= accepted request, else A.valid <= 0.
REQ-025 Back-to-back: request accepted in same cycle A advances appears on bus next cycle with zero bubble.
REQ-026 Edge with EXTM_HREADY=0 (no error): A, D, and all bus outputs held stable.
REQ-027 Completion: edge with EXTM_HREADY=1 and D.valid; next cycle rsp_valid=1, rsp_error=EXTM_HRESP, rsp_rdata=EXTM_HRDATA if read and not error, else 0.
REQ-028 Error first cycle (EXTM_HRESP=1, EXTM_HREADY=0, D.valid): set cancel; next cycle EXTM_HTRANS=IDLE, A retained.
REQ-029 Error second cycle (EXTM_HRESP=1, EXTM_HREADY=1): D completes with rsp_error=1; D.valid <= 0 (IDLE not promoted); cancel cleared; retained A re-issued NONSEQ next cycle.
REQ-030 Responses returned strictly in request order; each accepted request produces exactly one rsp_valid pulse.
REQ-031 EXTM_HRESP=1 with no D.valid ignored.

Reset
REQ-032 While EXTM_HRST=1: A, D, cancel cleared; EXTM_HTRANS=00, EXTM_HADDR=0, EXTM_HWRITE=0, EXTM_HWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=0.
REQ-033 Reset mid-transfer: in-flight transfers dropped, no rsp_valid for them; first cycle after release req_ready=1, EXTM_HTRANS=IDLE.

Verification
REQ-034 Single read 0xE8000000, slave HREADY=1, HRDATA=0xFFFFFFFF -> HTRANS=10 one cycle, rsp_valid two cycles after accept, rsp_rdata=0xFFFFFFFF, rsp_error=0.
REQ-035 Write 0xE8000004 data 0x12345678 then read 0xE8000004 back-to-back -> HWDATA=0x12345678 in cycle read address is on bus; two in-order responses, no IDLE gap.
REQ-036 Read with slave HREADY=0 for 3 cycles -> HADDR/HTRANS/HWDATA stable throughout, req_ready=0 when A full, rsp_valid exactly once after HREADY returns.
REQ-037 Read A followed by read B; slave answers A with two-cycle ERROR -> HTRANS=IDLE during second error cycle, rsp A rsp_error=1 rsp_rdata=0, B re-issued and completes OKAY.
REQ-038 EXTM_HRST asserted while two transfers outstanding -> outputs immediately at reset values, no rsp_valid; new request after release completes normally.
